// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types for the pipeline memory arbiter: FSM states, grant encoding,
// default widths and the fixed-priority grant selector.
package pipe_mem_arbiter_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arb_grant_e;

  // The data port belongs to the older instruction, so it always wins.
  function automatic arb_grant_e arb_pick(input logic if_elig, input logic d_elig);
    if (d_elig) begin
      return GNT_D;
    end else if (if_elig) begin
      return GNT_I;
    end else begin
      return GNT_NONE;
    end
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_timeout_cnt.sv
// BUSY-cycle counter for the arbiter. Cleared on every grant; term rises in
// the TIMEOUT-th counted cycle so the FSM can abort at the end of that cycle.
module arb_timeout_cnt
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic term
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  assign term = (cnt == CNT_W'(TIMEOUT - 1));

  // Count un-acked BUSY cycles; clear has priority and the count parks at term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one variable-latency memory between instruction fetch and
// the MEM-stage data port. Transactions are serialised (data first), the
// backend interface is fully registered and a sticky error flags timeouts.
// Optional build macro MEM_ARB_PERF_EN adds saturating stall/conflict counters.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_conflict_cnt_o
`endif
);

  arb_state_e state;
  arb_grant_e grant;
  logic       if_elig;
  logic       d_elig;
  logic       busy;
  logic       tmo;

  // A request arriving in its own completion cycle is the one just served.
  assign if_elig = if_req_i & ~if_valid_o;
  assign d_elig  = d_req_i & ~d_valid_o;
  assign stall_o = if_elig | d_elig;
  assign grant   = (state == IDLE) ? arb_pick(if_elig, d_elig) : GNT_NONE;
  assign busy    = (state == BUSY_I) || (state == BUSY_D);

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk  (clk_i),
    .rst_n(rst_i),
    .clear(grant != GNT_NONE),
    .en   (busy && !mem_ack_i),
    .term (tmo)
  );

  // Arbitration FSM with registered backend request and completion outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      if_valid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_valid_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      d_valid_o  <= 1'b0;
      case (state)
        IDLE: begin
          case (grant)
            GNT_D: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              state       <= BUSY_D;
            end
            GNT_I: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              state       <= BUSY_I;
            end
            default: ;
          endcase
        end
        BUSY_I: begin
          if (mem_ack_i) begin
            if_rdata_o <= mem_rdata_i;
            if_valid_o <= 1'b1;
            mem_req_o  <= 1'b0;
            state      <= IDLE;
          end else if (tmo) begin
            if_rdata_o <= '0;
            if_valid_o <= 1'b1;
            err_o      <= 1'b1;
            mem_req_o  <= 1'b0;
            state      <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              d_rdata_o <= mem_rdata_i;
            end
            d_valid_o <= 1'b1;
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end else if (tmo) begin
            d_rdata_o <= '0;
            d_valid_o <= 1'b1;
            err_o     <= 1'b1;
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating counters for stalled cycles and IDLE cycles with both ports eligible.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_stall_cnt_o    <= '0;
      perf_conflict_cnt_o <= '0;
    end else begin
      if (stall_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if ((state == IDLE) && if_elig && d_elig && (perf_conflict_cnt_o != 32'hFFFF_FFFF)) begin
        perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: directed transactions push their
// expected completions and backend requests into queues; a monitor and a
// backend model pop and compare as the DUT presents them.
module tb_pipe_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_valid_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_stall_cnt_o;
  logic [31:0]       perf_conflict_cnt_o;
`endif

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          noack;
    int          start;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   stall_seen = 0;

  pipe_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .if_req_i           (if_req_i),
    .if_addr_i          (if_addr_i),
    .if_rdata_o         (if_rdata_o),
    .if_valid_o         (if_valid_o),
    .d_req_i            (d_req_i),
    .d_we_i             (d_we_i),
    .d_addr_i           (d_addr_i),
    .d_wdata_i          (d_wdata_i),
    .d_rdata_o          (d_rdata_o),
    .d_valid_o          (d_valid_o),
    .stall_o            (stall_o),
    .mem_req_o          (mem_req_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_ack_i          (mem_ack_i),
    .mem_rdata_i        (mem_rdata_i),
    .err_o              (err_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cnt_o   (perf_stall_cnt_o),
    .perf_conflict_cnt_o(perf_conflict_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i && stall_o) stall_seen <= stall_seen + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input bit is_d, input logic [31:0] rdata, input int cycle);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.cycle = cycle;
    exp_q.push_back(e);
  endtask

  task automatic pushMem(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, input bit noack, input int start);
    mem_t m;
    m.we    = we;
    m.addr  = addr;
    m.wdata = wdata;
    m.rdata = rdata;
    m.delay = delay;
    m.noack = noack;
    m.start = start;
    mem_q.push_back(m);
  endtask

  task automatic applyStimulus(input bit set_i, input logic [31:0] i_addr, input bit set_d,
                               input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (set_i) begin
      if_req_i  = 1'b1;
      if_addr_i = i_addr;
    end
    if (set_d) begin
      d_req_i   = 1'b1;
      d_we_i    = we;
      d_addr_i  = addr;
      d_wdata_i = wdata;
    end
  endtask

  // Wait (bounded) for a completion pulse, optionally checking stall and dropping req.
  task automatic waitValid(input bit is_d, input bit chk_stall, input bit drop);
    int  n    = 0;
    bit  seen = 0;
    while (!seen && n <= 40) begin
      @(negedge clk_i);
      if (is_d ? d_valid_o : if_valid_o) begin
        seen = 1;
      end else begin
        if (chk_stall) checkOutput("stall_while_pending", 32'(stall_o), 32'd1);
        n++;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_valid_timeout: no %s valid pulse within 40 cycles", is_d ? "data" : "fetch");
    end else if (chk_stall) begin
      checkOutput("stall_in_valid_cycle", 32'(stall_o), 32'd0);
    end
    if (drop) begin
      if (is_d) d_req_i = 1'b0;
      else      if_req_i = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i && (if_valid_o || d_valid_o)) begin
        checkOutput("one_valid_at_a_time", 32'(if_valid_o & d_valid_o), 32'd0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_valid: if_valid=%0b d_valid=%0b with nothing expected (cycle %0d)",
                   if_valid_o, d_valid_o, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("valid_port_is_d", 32'(d_valid_o), 32'(e.is_d));
          checkOutput(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata_o : if_rdata_o, e.rdata);
          if (e.cycle >= 0) checkOutput("valid_cycle", 32'(cyc), 32'(e.cycle));
        end
      end
    end
  end

  initial begin : backend
    mem_t m;
    bit   active;
    int   waited;
    active      = 0;
    waited      = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk_i);
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'hBAD0_BAD0;
      if (!mem_req_o) begin
        active = 0;
      end else if (!active) begin
        active = 1;
        waited = 0;
        if (mem_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_mem_req: addr 0x%08h with nothing expected (cycle %0d)", mem_addr_o, cyc);
          m.we = mem_we_o; m.addr = mem_addr_o; m.wdata = mem_wdata_o;
          m.rdata = 32'd0; m.delay = 0; m.noack = 0; m.start = -1;
        end else begin
          m = mem_q.pop_front();
          checkOutput("mem_addr", mem_addr_o, m.addr);
          checkOutput("mem_we", 32'(mem_we_o), 32'(m.we));
          if (m.we) checkOutput("mem_wdata", mem_wdata_o, m.wdata);
          if (m.start >= 0) checkOutput("mem_req_cycle", 32'(cyc), 32'(m.start));
        end
      end else begin
        waited++;
        checkOutput("mem_addr_hold", mem_addr_o, m.addr);
        checkOutput("mem_we_hold", 32'(mem_we_o), 32'(m.we));
        if (m.we) checkOutput("mem_wdata_hold", mem_wdata_o, m.wdata);
      end
      if (active && !m.noack && waited == m.delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = m.rdata;
        active      = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int t;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] ps0;
    logic [31:0] pc0;
    int          ss0;
`endif
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    rst_i     = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("[TB] reset state");
    checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid_o), 32'd0);
    checkOutput("rst_d_valid", 32'(d_valid_o), 32'd0);
    checkOutput("rst_if_rdata", if_rdata_o, 32'd0);
    checkOutput("rst_d_rdata", d_rdata_o, 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
`ifdef MEM_ARB_PERF_EN
    checkOutput("rst_perf_stall", perf_stall_cnt_o, 32'd0);
    checkOutput("rst_perf_conflict", perf_conflict_cnt_o, 32'd0);
`endif
    rst_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] single fetch, ack 3 cycles after request");
    t = cyc;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    pushMem(1'b0, 32'h40, 32'h0, 32'h8C01_0004, 3, 1'b0, t + 1);
    pushExp(1'b0, 32'h8C01_0004, t + 5);
    waitValid(1'b0, 1'b1, 1'b1);
    @(negedge clk_i);

    $display("[TB] simultaneous fetch and load, zero-wait backend");
`ifdef MEM_ARB_PERF_EN
    ps0 = perf_stall_cnt_o;
    pc0 = perf_conflict_cnt_o;
    ss0 = stall_seen;
`endif
    t = cyc;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
    pushMem(1'b0, 32'h100, 32'h0, 32'h1122_3344, 0, 1'b0, t + 1);
    pushMem(1'b0, 32'h40, 32'h0, 32'h0000_0013, 0, 1'b0, t + 3);
    pushExp(1'b1, 32'h1122_3344, t + 2);
    pushExp(1'b0, 32'h0000_0013, t + 4);
    waitValid(1'b1, 1'b0, 1'b1);
    waitValid(1'b0, 1'b0, 1'b1);
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_conflict_delta", perf_conflict_cnt_o - pc0, 32'd1);
    checkOutput("perf_stall_delta", perf_stall_cnt_o - ps0, 32'd4);
    checkOutput("perf_stall_vs_observed", perf_stall_cnt_o - ps0, 32'(stall_seen - ss0));
`endif
    checkOutput("err_still_clear", 32'(err_o), 32'd0);
    @(negedge clk_i);

    $display("[TB] store keeps d_rdata");
    t = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    pushMem(1'b1, 32'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 1'b0, t + 1);
    pushExp(1'b1, 32'h1122_3344, t + 4);
    waitValid(1'b1, 1'b1, 1'b1);
    d_we_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] fetch timeout");
    t = cyc;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
    pushMem(1'b0, 32'h200, 32'h0, 32'h0, 0, 1'b1, t + 1);
    pushExp(1'b0, 32'h0, t + 1 + TIMEOUT);
    waitValid(1'b0, 1'b0, 1'b1);
    checkOutput("timeout_err", 32'(err_o), 32'd1);
    checkOutput("timeout_mem_req_dropped", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    checkOutput("err_sticky", 32'(err_o), 32'd1);

    $display("[TB] back-to-back fetches");
    t = cyc;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
    pushMem(1'b0, 32'h80, 32'h0, 32'hAAAA_0001, 0, 1'b0, t + 1);
    pushExp(1'b0, 32'hAAAA_0001, t + 2);
    waitValid(1'b0, 1'b0, 1'b0);
    t = cyc;
    if_addr_i = 32'h84;
    pushMem(1'b0, 32'h84, 32'h0, 32'hAAAA_0002, 0, 1'b0, t + 2);
    pushExp(1'b0, 32'hAAAA_0002, t + 3);
    waitValid(1'b0, 1'b0, 1'b1);
    checkOutput("err_sticky_after_ok", 32'(err_o), 32'd1);
    @(negedge clk_i);

    $display("[TB] asynchronous reset during a data transaction");
    t = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    pushMem(1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b1, t + 1);
    repeat (2) @(negedge clk_i);
    checkOutput("busy_before_reset", 32'(mem_req_o), 32'd1);
    #2;
    rst_i   = 1'b0;
    d_req_i = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("async_rst_err", 32'(err_o), 32'd0);
    checkOutput("async_rst_stall", 32'(stall_o), 32'd0);
    checkOutput("async_rst_d_rdata", d_rdata_o, 32'd0);
    checkOutput("async_rst_if_rdata", if_rdata_o, 32'd0);
    checkOutput("async_rst_mem_addr", mem_addr_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      checkOutput("post_reset_no_mem_req", 32'(mem_req_o), 32'd0);
      checkOutput("post_reset_no_d_valid", 32'(d_valid_o), 32'd0);
    end

    checkOutput("pending_valid_expectations", 32'(exp_q.size()), 32'd0);
    checkOutput("pending_mem_expectations", 32'(mem_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipelined CPU's instruction-fetch port (read-only) and MEM-stage data port (read/write).
- Sits between the IF/MEM stages and the memory backend.
- Serialises transactions through a small FSM with a req/ack handshake on each side.
- Drives a pipeline-wide stall while any accepted request is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT, 64, max BUSY cycles waiting for mem_ack_i before abort (≥2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction; valid with if_valid_o.
- if_valid_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  data request; held until d_valid_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data; valid with d_valid_o.
- d_valid_o  out  1  one-cycle data completion pulse.
- stall_o  out  1  freeze PC and pipeline registers.
- mem_req_o  out  1  backend request, registered.
- mem_we_o  out  1  backend write enable, registered.
- mem_addr_o  out  ADDR_W  backend address, registered.
- mem_wdata_o  out  DATA_W  backend write data, registered.
- mem_ack_i  in  1  backend completion, one cycle.
- mem_rdata_i  in  DATA_W  backend read data, valid with mem_ack_i.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; all outputs 0, including rdata outputs and err_o. mem_req_o drops immediately; any in-flight transaction is discarded, with no valid pulse.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, eligibility: a port is eligible when req=1 and its valid_o=0 this cycle. A request seen in its own completion cycle is ignored.
- IDLE, arbitration: data wins over fetch (the older instruction). On grant, register addr/we/wdata into mem_*_o, set mem_req_o=1 and go to BUSY_D or BUSY_I. Fetch grants force mem_we_o=0.
- BUSY_x: hold mem_* outputs stable until mem_ack_i=1.
- On ack:
  - Capture mem_rdata_i into x_rdata_o (stores capture nothing, so d_rdata_o keeps its old value).
  - Pulse x_valid_o for the next cycle.
  - Clear mem_req_o and return to IDLE.
- Timing: fixed 2-cycle minimum. Request at cycle T is granted at T, mem_req_o=1 at T+1, ack at T+1 gives valid at T+2.
- Back-to-back: a requester holding req through its valid cycle is re-granted at valid+1.
- Ack handling: mem_ack_i is ignored in IDLE.
- Timeout: a BUSY cycle counter counts up. When it reaches TIMEOUT without ack:
  - set err_o (cleared only by reset);
  - pulse x_valid_o with x_rdata_o = 0;
  - drop mem_req_o and return to IDLE.
  The counter clears on every grant.
- stall_o (combinational) = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o).
- Simultaneous requests in IDLE: D is served, then I is granted in D's valid cycle. I is not blocked by D's masking, so there is no idle cycle between the two.
- Request drops: requesters never drop req before valid. If one does, the transaction still completes and the valid pulse is issued.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_conflict_cnt_o[31:0].
  - perf_stall_cnt_o counts cycles with stall_o=1.
  - perf_conflict_cnt_o counts IDLE cycles where both ports are eligible.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: FSM state enum (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2), grant-select encoding and default widths.
- One natural sub-module: arb_timeout_cnt, a loadable BUSY counter with a terminal-count output.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x40; backend acks 3 cycles after mem_req_o with 0x8C010004 -> mem_addr_o=0x40, mem_we_o=0, if_valid_o one cycle with if_rdata_o=0x8C010004, stall_o high until the valid cycle.
- Conflict: if_req_i and d_req_i rise together; d is a load at 0x100; zero-wait ack -> D granted first, d_valid_o at T+2, mem_addr_o=0x40 at T+3, if_valid_o at T+4.
- Store: d_we_i=1, d_addr_i=0x20, d_wdata_i=0xDEADBEEF -> mem_we_o=1 with those values held until ack; d_rdata_o unchanged.
- Timeout: TIMEOUT=8, no ack -> after 8 BUSY cycles: if_valid_o=1, if_rdata_o=0, err_o=1 sticky, mem_req_o=0.
- Reset mid-BUSY: assert rst_i=0 asynchronously during BUSY_D -> mem_req_o, stall-path state and err_o go to 0 immediately; no d_valid_o after release.
- MEM_ARB_PERF_EN: run the conflict scenario -> perf_conflict_cnt_o=1; perf_stall_cnt_o equals the observed stall_o-high cycles.
